button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_if.sv | 13 +
 rtl/button_debouncer.sv | 106 ++++++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// Button bus between the pin side (master) and the debouncer (slave).
// Raw pins go in; the debounced level and the edge strobes come out.
interface button_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  modport master (output btn_raw, input btn_out, press_pulse, release_pulse);
  modport slave  (input btn_raw, output btn_out, press_pulse, release_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: 2-flop sync, polarity normalise, then a
// per-channel hold counter that accepts a level only after it stays stable.
module button_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_RAW = (ACTIVE_LOW != 0);

  typedef enum logic {STABLE, COUNTING} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2;
  logic          stb, stb_nxt;
  logic          press_nxt, rel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lvl, lvl_nxt;

  assign lvl     = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  // sync1 is next cycle's sync2, so the state register tracks lvl != stb exactly
  assign lvl_nxt = (ACTIVE_LOW != 0) ? ~sync1 : sync1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= IDLE_RAW;
      sync2         <= IDLE_RAW;
      state         <= STABLE;
      stb           <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      state         <= state_nxt;
      stb           <= stb_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= rel_nxt;
    end
  end

  always_comb begin
    stb_nxt   = stb;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      STABLE: cnt_nxt = '0;
      COUNTING: begin
        if (cnt == CNT_LAST) begin
          stb_nxt   = ~stb;
          press_nxt = ~stb;
          rel_nxt   = stb;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: cnt_nxt = '0;
    endcase
    state_nxt = (lvl_nxt != stb_nxt) ? COUNTING : STABLE;
  end

  assign btn_out = stb;

  logic unused_lvl;
  assign unused_lvl = lvl;
endmodule

module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  button_debouncer_if.slave  bus
);
  logic [WIDTH-1:0] out_v, press_v, rel_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw           (bus.btn_raw[i]),
      .btn_out       (out_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (rel_v[i])
    );
  end

  assign bus.btn_out       = out_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = rel_v;
endmodule
